// File: rtl/tm_pkg.sv
// tm_pkg: shared widths, FSM states and clause polarity for the Tsetlin Machine pipeline
package tm_pkg;
  typedef enum logic [1:0] {S_RUN, S_CLASS_END, S_DONE} state_t;
  function automatic int sum_w(input int clauses);
    return $clog2(clauses + 1) + 1;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic signed [1:0] polarity(input logic lsb);
    return lsb ? -2'sd1 : 2'sd1;
  endfunction
endpackage

// File: rtl/tm_clause_eval.sv
// tm_clause_eval: accumulates fail/any_inc over a clause's chunks; ports: clk, rst_flag (sync active-low), en (beat accepted), last (final chunk), ta_include, xin -> clause_out, clause_done (same-cycle pulse on the final beat)
module tm_clause_eval #(
  parameter int INT_SIZE = 32,
  parameter logic [INT_SIZE-1:0] FILTER = '1
) (
  input  logic                clk,
  input  logic                rst_flag,
  input  logic                en,
  input  logic                last,
  input  logic [INT_SIZE-1:0] ta_include,
  input  logic [INT_SIZE-1:0] xin,
  output logic                clause_out,
  output logic                clause_done
);
  logic fail_q, inc_q, fail_n, inc_n;
  logic [INT_SIZE-1:0] inc_f;
  always_comb begin
    inc_f = last ? ta_include & FILTER : ta_include;
    fail_n = fail_q | (|(inc_f & ~xin));
    inc_n = inc_q | (|inc_f);
    clause_done = en & last;
    clause_out = !fail_n && inc_n;
  end
  always_ff @(posedge clk)
    if (!rst_flag || clause_done) begin
      fail_q <= 1'b0;
      inc_q <= 1'b0;
    end else if (en) begin
      fail_q <= fail_n;
      inc_q <= inc_n;
    end
endmodule

// File: rtl/tm_multiclass_pipeline.sv
// tm_multiclass_pipeline: streamed multi-class TM inference with arg-max; ports: clk, rst_flag (sync active-low), stop_flag (stall), in_valid/in_ready/ta_include/xin beat stream, out_valid/out_ready/pred_class/pred_sum result, busy
module tm_multiclass_pipeline
  import tm_pkg::*;
#(
  parameter int CLASSES = 10,
  parameter int CLAUSES = 2000,
  parameter int LA_CHUNKS = 49,
  parameter int INT_SIZE = 32,
  parameter logic [INT_SIZE-1:0] FILTER = '1,
  parameter int THRESHOLD = 128
) (
  input  logic                                clk,
  input  logic                                rst_flag,
  input  logic                                stop_flag,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [INT_SIZE-1:0]                 ta_include,
  input  logic [INT_SIZE-1:0]                 xin,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [idx_w(CLASSES)-1:0]           pred_class,
  output logic signed [sum_w(CLAUSES)-1:0]    pred_sum,
  output logic                                busy
);
  localparam int SW = sum_w(CLAUSES);
  localparam int CW = idx_w(CLASSES);
  localparam int KW = idx_w(CLAUSES);
  localparam int JW = idx_w(LA_CHUNKS);
  state_t state, state_n;
  logic [JW-1:0] chunk;
  logic [KW-1:0] clause;
  logic [CW-1:0] cls, best_idx;
  logic signed [SW-1:0] sum, best, clamped;
  int sum_i;
  logic accept, last_chunk, last_clause, last_class, clause_out, clause_done, take, handshake;
  tm_clause_eval #(.INT_SIZE(INT_SIZE), .FILTER(FILTER)) u_eval (
    .clk(clk), .rst_flag(rst_flag), .en(accept), .last(last_chunk),
    .ta_include(ta_include), .xin(xin), .clause_out(clause_out), .clause_done(clause_done)
  );
  always_comb begin
    in_ready = rst_flag && !stop_flag && state == S_RUN;
    accept = in_valid && in_ready;
    last_chunk = chunk == JW'(LA_CHUNKS - 1);
    last_clause = clause == KW'(CLAUSES - 1);
    last_class = cls == CW'(CLASSES - 1);
    handshake = out_valid && out_ready && !stop_flag;
    sum_i = int'(sum);
    clamped = SW'(sum_i > THRESHOLD ? THRESHOLD : sum_i < -THRESHOLD ? -THRESHOLD : sum_i);
    take = state == S_CLASS_END && (cls == '0 || clamped > best);
    state_n = stop_flag ? state
            : state == S_RUN ? (accept && last_chunk && last_clause ? S_CLASS_END : S_RUN)
            : state == S_CLASS_END ? (last_class ? S_DONE : S_RUN)
            : handshake ? S_RUN : S_DONE;
  end
  always_ff @(posedge clk)
    if (!rst_flag) begin
      state <= S_RUN;
      chunk <= '0;
      clause <= '0;
      cls <= '0;
      sum <= '0;
      best <= '0;
      best_idx <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else if (!stop_flag) begin
      state <= state_n;
      busy <= (busy | accept) & !handshake;
      out_valid <= state == S_DONE && !handshake;
      if (accept) begin
        chunk <= last_chunk ? '0 : chunk + 1'b1;
        if (last_chunk) clause <= last_clause ? '0 : clause + 1'b1;
      end
      if (clause_done && clause_out) sum <= sum + SW'(polarity(clause[0]));
      if (state == S_CLASS_END) begin
        sum <= '0;
        if (!last_class) cls <= cls + 1'b1;
      end
      if (take) begin
        best <= clamped;
        best_idx <= cls;
      end
      if (handshake) begin
        cls <= '0;
        best <= '0;
        best_idx <= '0;
      end
    end
  assign pred_class = best_idx;
  assign pred_sum = best;
endmodule

// File: tb/tb_tm_multiclass_pipeline.sv
// tb_tm_multiclass_pipeline: table-driven, directed and randomized checks of two pipeline configurations against a clause-level reference model
module tb_tm_multiclass_pipeline;
  logic clk = 0, rst_flag = 0, stop_flag = 0, in_valid = 0, out_ready = 0, sel = 0;
  logic [7:0] ta_include = 0, xin = 0;
  logic iv_a, iv_b, rdy_a, rdy_b, ov_a, ov_b, busy_a, busy_b, pc_a, pc_b;
  logic signed [3:0] ps_a;
  logic signed [4:0] ps_b;
  logic rdy, ov, bsy;
  int pc, ps;
  int checks = 0, failures = 0;
  logic [7:0] inc_m[2][8][2], x_m[2][8][2];
  always #5 clk = ~clk;
  assign iv_a = in_valid && !sel;
  assign iv_b = in_valid && sel;
  always_comb begin
    rdy = sel ? rdy_b : rdy_a;
    ov = sel ? ov_b : ov_a;
    bsy = sel ? busy_b : busy_a;
    pc = sel ? int'(pc_b) : int'(pc_a);
    ps = sel ? int'(ps_b) : int'(ps_a);
  end
  tm_multiclass_pipeline #(.CLASSES(2), .CLAUSES(4), .LA_CHUNKS(2), .INT_SIZE(8), .FILTER(8'h0F), .THRESHOLD(2)) dut_a (
    .clk(clk), .rst_flag(rst_flag), .stop_flag(stop_flag), .in_valid(iv_a), .in_ready(rdy_a),
    .ta_include(ta_include), .xin(xin), .out_valid(ov_a), .out_ready(out_ready),
    .pred_class(pc_a), .pred_sum(ps_a), .busy(busy_a));
  tm_multiclass_pipeline #(.CLASSES(2), .CLAUSES(8), .LA_CHUNKS(2), .INT_SIZE(8), .FILTER(8'h0F), .THRESHOLD(2)) dut_b (
    .clk(clk), .rst_flag(rst_flag), .stop_flag(stop_flag), .in_valid(iv_b), .in_ready(rdy_b),
    .ta_include(ta_include), .xin(xin), .out_valid(ov_b), .out_ready(out_ready),
    .pred_class(pc_b), .pred_sum(ps_b), .busy(busy_b));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  function automatic void model(input int ncl, output int ecls, output int esum);
    int s, best;
    bit f, a;
    logic [7:0] m;
    best = 0;
    ecls = 0;
    for (int c = 0; c < 2; c++) begin
      s = 0;
      for (int k = 0; k < ncl; k++) begin
        f = 0;
        a = 0;
        for (int j = 0; j < 2; j++) begin
          m = j == 1 ? inc_m[c][k][j] & 8'h0F : inc_m[c][k][j];
          f |= |(m & ~x_m[c][k][j]);
          a |= |m;
        end
        if (!f && a) s += (k % 2) ? -1 : 1;
      end
      s = s > 2 ? 2 : s < -2 ? -2 : s;
      if (c == 0 || s > best) begin
        best = s;
        ecls = c;
      end
    end
    esum = best;
  endfunction

  task automatic clear_sample();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < 2; j++) begin
          inc_m[c][k][j] = 0;
          x_m[c][k][j] = 8'($urandom);
        end
  endtask

  task automatic fire(input int c, input int k);
    inc_m[c][k][0] = 8'h3C;
    x_m[c][k][0] = 8'hFF;
    inc_m[c][k][1] = 8'h05;
    x_m[c][k][1] = 8'h0F;
  endtask

  task automatic rand_sample(input int ncl);
    int r;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < ncl; k++) begin
        r = $urandom_range(3);
        for (int j = 0; j < 2; j++) begin
          inc_m[c][k][j] = r == 0 ? 8'h00 : 8'($urandom & $urandom);
          x_m[c][k][j] = 8'($urandom);
          if (r >= 2) x_m[c][k][j] |= inc_m[c][k][j];
        end
      end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_flag = 0;
    in_valid = 0;
    stop_flag = 0;
    out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    rst_flag = 1;
  endtask

  task automatic send(input logic [7:0] i, input logic [7:0] x, input bit rnd);
    bit go;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      stop_flag = rnd && $urandom_range(4) == 0;
      in_valid = !(rnd && $urandom_range(3) == 0);
      ta_include = in_valid ? i : 8'($urandom);
      xin = in_valid ? x : 8'($urandom);
      #1 go = in_valid && rdy;
      @(posedge clk);
      if (go) return;
    end
    $display("FAIL beat_accept: got no handshake expected handshake within 200 cycles");
    failures++;
    $fatal(1, "beat never accepted");
  endtask

  task automatic drive(input int ncl, input bit rnd, input int limit);
    int n = 0;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < ncl; k++)
        for (int j = 0; j < 2; j++) begin
          if (n == limit) return;
          n++;
          send(inc_m[c][k][j], x_m[c][k][j], rnd);
        end
  endtask

  task automatic finish(input string nm, input int ecls, input int esum, input bit rnd);
    int lat;
    int pc0, ps0;
    @(negedge clk);
    in_valid = 0;
    stop_flag = 0;
    lat = 1;
    while (!ov && lat < 40) begin
      @(negedge clk);
      lat++;
      stop_flag = rnd && $urandom_range(3) == 0;
    end
    stop_flag = 0;
    check({nm, "_out_valid"}, 32'(ov), 1);
    if (!ov) begin
      apply_reset();
      return;
    end
    if (!rnd) check({nm, "_latency"}, lat, 3);
    #1 check({nm, "_no_ready_in_done"}, 32'(rdy), 0);
    check({nm, "_class"}, pc, ecls);
    check({nm, "_sum"}, ps, esum);
    if (rnd) begin
      pc0 = pc;
      ps0 = ps;
      for (int i = 0; i < 5; i++) @(negedge clk);
      stop_flag = 1;
      out_ready = 1;
      @(negedge clk);
      check({nm, "_held_valid"}, 32'(ov), 1);
      check({nm, "_held_pred"}, {pc[15:0], ps[15:0]}, {pc0[15:0], ps0[15:0]});
      stop_flag = 0;
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    #1;
    check({nm, "_valid_cleared"}, 32'(ov), 0);
    check({nm, "_busy_cleared"}, 32'(bsy), 0);
    check({nm, "_ready_after"}, 32'(rdy), 1);
  endtask

  task automatic run(input string nm, input int ncl, input int ecls, input int esum, input bit rnd);
    sel = ncl == 8;
    drive(ncl, rnd, 1 << 30);
    finish(nm, ecls, esum, rnd);
  endtask

  typedef struct {
    string nm;
    logic [3:0] f0, f1;
    int ecls, esum;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int ec, es;
    tbl[0] = '{"c0_even", 4'b0101, 4'b0000, 0, 2};
    tbl[1] = '{"tie", 4'b0101, 4'b0101, 0, 2};
    tbl[2] = '{"c1_wins", 4'b0001, 4'b0101, 1, 2};
    tbl[3] = '{"neg_both", 4'b1010, 4'b1010, 0, -2};
    tbl[4] = '{"c1_neg", 4'b0000, 4'b1000, 0, 0};
    tbl[5] = '{"c1_pos", 4'b0000, 4'b0100, 1, 1};
    tbl[6] = '{"cancel", 4'b0011, 4'b0111, 1, 1};
    apply_reset();
    rst_flag = 0;
    #1;
    check("reset_ready", 32'(rdy), 0);
    @(negedge clk);
    rst_flag = 1;
    #1;
    check("reset_valid", 32'(ov), 0);
    check("reset_busy", 32'(bsy), 0);
    check("reset_pred", {pc[15:0], ps[15:0]}, 0);
    for (int t = 0; t < 7; t++) begin
      clear_sample();
      for (int k = 0; k < 4; k++) begin
        if (tbl[t].f0[k]) fire(0, k);
        if (tbl[t].f1[k]) fire(1, k);
      end
      run(tbl[t].nm, 4, tbl[t].ecls, tbl[t].esum, 0);
    end
    clear_sample();
    inc_m[0][0][0] = 8'h01; x_m[0][0][0] = 8'h01;
    inc_m[0][0][1] = 8'h80; x_m[0][0][1] = 8'h00;
    run("filter_last", 4, 0, 1, 0);
    clear_sample();
    inc_m[1][0][0] = 8'h81; x_m[1][0][0] = 8'h01;
    inc_m[1][0][1] = 8'h01; x_m[1][0][1] = 8'h01;
    run("filter_first", 4, 0, 0, 0);
    clear_sample();
    inc_m[1][0][1] = 8'h80; x_m[1][0][1] = 8'h00;
    run("filter_empty", 4, 0, 0, 0);
    clear_sample();
    fire(0, 0); fire(0, 2);
    for (int k = 0; k < 8; k += 2) fire(1, k);
    run("clamp_pos", 8, 0, 2, 0);
    clear_sample();
    for (int k = 1; k < 8; k += 2) fire(0, k);
    fire(1, 1); fire(1, 3); fire(1, 5);
    run("clamp_neg", 8, 0, -2, 0);
    for (int n = 0; n < 16; n++) begin
      int ncl;
      ncl = (n % 4 == 3) ? 8 : 4;
      clear_sample();
      rand_sample(ncl);
      model(ncl, ec, es);
      run($sformatf("rand%0d", n), ncl, ec, es, n[0]);
    end
    sel = 0;
    clear_sample();
    rand_sample(4);
    drive(4, 0, 11);
    @(negedge clk);
    in_valid = 0;
    rst_flag = 0;
    #1 check("midrst_ready", 32'(rdy), 0);
    @(negedge clk);
    rst_flag = 1;
    #1;
    check("midrst_valid", 32'(ov), 0);
    check("midrst_busy", 32'(bsy), 0);
    rand_sample(4);
    model(4, ec, es);
    run("after_reset", 4, ec, es, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
